// File: rtl/cmutex_merge_n.sv
// N-way drive/free mutex merge: arbitrates pending drives onto one downstream port and returns frees in order.
// Build option CMERGE_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module cmutex_merge_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drive,
  input  logic [W-1:0] data,
  input  logic         grant,
  input  logic         release_hit,
  output logic         pending,
  output logic         drive_err,
  output logic [W-1:0] data_q
);
  typedef enum logic [1:0] {IDLE, PENDING, ISSUED} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && drive) data_q <= data;
    end
  end

  // A drive on a busy channel is flagged and otherwise dropped.
  always_comb begin
    state_d   = state_q;
    drive_err = 1'b0;
    case (state_q)
      IDLE:    if (drive) state_d = PENDING;
      PENDING: begin
        drive_err = drive;
        if (grant) state_d = ISSUED;
      end
      ISSUED:  begin
        drive_err = drive;
        if (release_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending = (state_q == PENDING);
endmodule

module cmutex_merge_n #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_drive,
  input  logic [N*W-1:0] i_data,
  output logic [N-1:0]   o_free,
  output logic           o_driveNext,
  output logic [W-1:0]   o_dataNext,
  output logic [CW-1:0]  o_chanNext,
  input  logic           i_freeNext,
  output logic           o_err
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [N-1:0]              pending, drive_err, grant_vec, release_hit;
  logic [N-1:0][W-1:0]       lane_data;
  logic [DEPTH-1:0][CW-1:0]  fifo_q;
  logic [PW-1:0]             wr_q, rd_q;
  logic [CNTW-1:0]           cnt_q;
  logic [CW-1:0]             gnt_id, head;
  logic                      found, push, pop, err_ev;
  int                        idx;

  for (genvar k = 0; k < N; k++) begin : g_lane
    cmutex_merge_lane #(.W(W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .drive       (i_drive[k]),
      .data        (i_data[k*W +: W]),
      .grant       (grant_vec[k]),
      .release_hit (release_hit[k]),
      .pending     (pending[k]),
      .drive_err   (drive_err[k]),
      .data_q      (lane_data[k])
    );
    assign grant_vec[k]   = push && (gnt_id == CW'(k));
    assign release_hit[k] = pop && (head == CW'(k));
  end

`ifdef CMERGE_RR_EN
  logic [CW-1:0] rr_q;
  // Pointer holds the last winner; starting at N-1 makes channel 0 first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_q <= CW'(N - 1);
    else if (push) rr_q <= gnt_id;
  end
`endif

  always_comb begin
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
`ifdef CMERGE_RR_EN
      idx = (int'(rr_q) + 1 + i) % N;
`else
      idx = i;
`endif
      if (!found && pending[idx]) begin
        found  = 1'b1;
        gnt_id = CW'(idx);
      end
    end
  end

  // Capacity is judged on the registered count, so a slot popped this cycle is only reusable next cycle.
  assign push   = found && (cnt_q < CNTW'(DEPTH));
  assign pop    = i_freeNext && (cnt_q != '0);
  assign head   = fifo_q[rd_q];
  assign err_ev = (|drive_err) || (i_freeNext && cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      o_dataNext  <= '0;
      o_chanNext  <= '0;
      o_err       <= 1'b0;
    end else begin
      o_driveNext <= push;
      o_free      <= release_hit;
      o_err       <= o_err | err_ev;
      if (push) begin
        o_dataNext   <= lane_data[gnt_id];
        o_chanNext   <= gnt_id;
        fifo_q[wr_q] <= gnt_id;
        wr_q         <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
